switch_debounce: RTL and testbench



---
 rtl/switch_debounce.sv | 155 +++++++++++++++
 tb/tb_switch_debounce.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// ----------------------------------------------------------------------------
// switch_debounce
//
// Per-switch two-flop synchronizer and debouncer for the board push-buttons.
// Each channel drives a clean active-low level toward the interrupt pulse
// stage. It also emits one-cycle press/release strobes and a registered OR of
// the press strobes.
//
// Optional build macro:
//   DEBOUNCE_AUTOREPEAT_EN - while a switch stays pressed, press_pulse
//                            re-fires every REPEAT_CYCLES cycles.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high reset
//   sw_raw         raw switch pins, active-low (0 = pressed), asynchronous
//   sw_db          debounced level, same polarity as sw_raw
//   press_pulse    one-cycle strobe per accepted 1->0 transition
//   release_pulse  one-cycle strobe per accepted 0->1 transition
//   any_press      OR of press_pulse, asserted in the same cycle
// ----------------------------------------------------------------------------
module switch_debounce #(
  parameter int unsigned NUM_SW          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_db,
  output logic [NUM_SW-1:0] press_pulse,
  output logic [NUM_SW-1:0] release_pulse,
  output logic              any_press
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RW = $clog2(REPEAT_CYCLES);
  localparam int unsigned CW = (DW > RW) ? DW : RW;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_COUNTING = 1'b1;

  logic [NUM_SW-1:0] s0;
  logic [NUM_SW-1:0] s1;
  logic [NUM_SW-1:0] state;
  logic [NUM_SW-1:0] state_nxt;
  logic [NUM_SW-1:0] db_nxt;
  logic [NUM_SW-1:0] press_nxt;
  logic [NUM_SW-1:0] release_nxt;
  logic [CW-1:0]     cnt     [NUM_SW];
  logic [CW-1:0]     cnt_nxt [NUM_SW];

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);

  logic [CW-1:0] rcnt     [NUM_SW];
  logic [CW-1:0] rcnt_nxt [NUM_SW];
`endif

  // Qualification FSM, evaluated for all channels in parallel.
  always_comb begin
    state_nxt   = state;
    db_nxt      = sw_db;
    press_nxt   = '0;
    release_nxt = '0;
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      cnt_nxt[i] = cnt[i];
      case (state[i])
        ST_STABLE: begin
          if (s1[i] != sw_db[i]) begin
            state_nxt[i] = ST_COUNTING;
            cnt_nxt[i]   = CNT_ONE;
          end else begin
            cnt_nxt[i]   = '0;
          end
        end
        default: begin
          if (s1[i] == sw_db[i]) begin
            // Bounce: the input came back before qualifying.
            state_nxt[i] = ST_STABLE;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            db_nxt[i]      = s1[i];
            press_nxt[i]   = ~s1[i];
            release_nxt[i] = s1[i];
            state_nxt[i]   = ST_STABLE;
            cnt_nxt[i]     = '0;
          end else begin
            cnt_nxt[i]     = cnt[i] + CNT_ONE;
          end
        end
      endcase
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    // The repeat counter restarts on the initial press commit and is held at
    // zero while released. A release commit forces db_nxt high, so a repeat
    // strobe can never coincide with a release strobe.
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      if (db_nxt[i] || press_nxt[i]) begin
        rcnt_nxt[i] = '0;
      end else if (rcnt[i] == RPT_LAST) begin
        rcnt_nxt[i]  = '0;
        press_nxt[i] = 1'b1;
      end else begin
        rcnt_nxt[i]  = rcnt[i] + CNT_ONE;
      end
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s0            <= '1;
      s1            <= '1;
      sw_db         <= '1;
      state         <= {NUM_SW{ST_STABLE}};
      press_pulse   <= '0;
      release_pulse <= '0;
      any_press     <= 1'b0;
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s0            <= sw_raw;
      s1            <= s0;
      sw_db         <= db_nxt;
      state         <= state_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      any_press     <= |press_nxt;
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        rcnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        rcnt[i] <= rcnt_nxt[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// ----------------------------------------------------------------------------
// tb_switch_debounce
//
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10
// and NUM_SW=2. The main sequences come from a per-cycle vector table. The
// reset-mid-count and held-switch cases are written out by hand.
// ----------------------------------------------------------------------------
module tb_switch_debounce;

  localparam int unsigned NSW = 2;
  localparam int unsigned DB  = 4;
  localparam int unsigned RP  = 10;

  logic           clock = 1'b0;
  logic           reset;
  logic [NSW-1:0] sw_raw;
  logic [NSW-1:0] sw_db;
  logic [NSW-1:0] press_pulse;
  logic [NSW-1:0] release_pulse;
  logic           any_press;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  switch_debounce #(
    .NUM_SW(NSW),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES(RP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sw_raw(sw_raw),
    .sw_db(sw_db),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .any_press(any_press)
  );

  typedef struct {
    logic [1:0] raw;
    logic [1:0] db;
    logic [1:0] pr;
    logic [1:0] rl;
    logic       any;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_n(input int n, input logic [1:0] raw, input logic [1:0] db,
                       input logic [1:0] pr, input logic [1:0] rl, input logic any);
    vec_t v;
    v.raw = raw;
    v.db  = db;
    v.pr  = pr;
    v.rl  = rl;
    v.any = any;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  // Advance one edge and sample just after it.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] db, input logic [1:0] pr,
                            input logic [1:0] rl, input logic any);
    check({tag, " sw_db"},         8'(sw_db),         8'(db));
    check({tag, " press_pulse"},   8'(press_pulse),   8'(pr));
    check({tag, " release_pulse"}, 8'(release_pulse), 8'(rl));
    check({tag, " any_press"},     8'(any_press),     8'(any));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    int first;
    int rel_seen;
    logic exp_p;

    reset  = 1'b1;
    sw_raw = 2'b11;
    tick;
    tick;
    check_outs("reset", 2'b11, 2'b00, 2'b00, 1'b0);
    reset = 1'b0;

    // Idle: nothing may move.
    for (int i = 0; i < 50; i++) begin
      tick;
      check_outs($sformatf("idle%0d", i), 2'b11, 2'b00, 2'b00, 1'b0);
    end

    // Press ch0: commit at the 6th edge, strobe lasts one cycle.
    add_n(5, 2'b10, 2'b11, 2'b00, 2'b00, 1'b0);
    add_n(1, 2'b10, 2'b10, 2'b01, 2'b00, 1'b1);
    add_n(2, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
    // Release ch0.
    add_n(5, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0);
    add_n(1, 2'b11, 2'b11, 2'b00, 2'b01, 1'b0);
    add_n(2, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
    // 3-cycle glitch on ch0 is rejected.
    add_n(3, 2'b10, 2'b11, 2'b00, 2'b00, 1'b0);
    add_n(8, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
    // Both channels pressed together, released 20 cycles later.
    add_n(5,  2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
    add_n(1,  2'b00, 2'b00, 2'b11, 2'b00, 1'b1);
    add_n(14, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    add_n(5,  2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
    add_n(1,  2'b11, 2'b11, 2'b00, 2'b11, 1'b0);
    add_n(3,  2'b11, 2'b11, 2'b00, 2'b00, 1'b0);

    foreach (vecs[k]) begin
      sw_raw = vecs[k].raw;
      tick;
      check_outs($sformatf("vec%0d", k), vecs[k].db, vecs[k].pr, vecs[k].rl, vecs[k].any);
    end

    // Reset asserted mid-count on ch1, switch still held at release.
    sw_raw = 2'b01;
    for (int i = 0; i < 4; i++) tick;
    check("pre-reset sw_db", 8'(sw_db), 8'(2'b11));
    reset = 1'b1;
    #1;
    check_outs("in-reset", 2'b11, 2'b00, 2'b00, 1'b0);
    tick;
    tick;
    check_outs("in-reset2", 2'b11, 2'b00, 2'b00, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick;
      check_outs($sformatf("requal%0d", i), (i >= 6) ? 2'b01 : 2'b11,
                 (i == 6) ? 2'b10 : 2'b00, 2'b00, (i == 6));
    end
    sw_raw   = 2'b11;
    rel_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (release_pulse[1]) rel_seen++;
    end
    check("requal release count", 8'(rel_seen), 8'(1));
    check("requal final sw_db", 8'(sw_db), 8'(2'b11));

    // Held switch: one press strobe, or periodic repeats when enabled.
    sw_raw = 2'b10;
    first  = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      tick;
      if (press_pulse[0]) first = i;
    end
    check("held first press edge", 8'(first), 8'(6));
    for (int i = 1; i <= 40; i++) begin
      tick;
`ifdef DEBOUNCE_AUTOREPEAT_EN
      exp_p = (i % 10 == 0);
`else
      exp_p = 1'b0;
`endif
      check($sformatf("held%0d press", i), 8'(press_pulse), 8'({1'b0, exp_p}));
      check($sformatf("held%0d any", i), 8'(any_press), 8'(exp_p));
    end
    sw_raw   = 2'b11;
    rel_seen = 0;
    for (int i = 1; i <= 15; i++) begin
      tick;
      check($sformatf("after-held%0d press", i), 8'(press_pulse), 8'(2'b00));
      if (release_pulse[0]) rel_seen++;
    end
    check("after-held release count", 8'(rel_seen), 8'(1));
    check("after-held sw_db", 8'(sw_db), 8'(2'b11));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
